mem_port_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory between two requesters: the fetch stage (instruction port) and the memory-access stage (data port).
- Serialises accesses with one outstanding transaction at a time, using a req/gnt/rvalid handshake on each side.
- Default policy is data-priority with a starvation guard.
- A flush input lets a taken branch discard an in-flight fetch response.

---
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data ports.
// Optional macro ARB_RR_EN: round-robin on contested grants instead of data priority.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t        r_state;
    logic          r_owner_d;
    logic          r_we;
    logic [2:0]    r_cnt;
    logic          r_flush_pend;
    logic          r_i_gnt;
    logic          r_i_rvalid;
    logic [DW-1:0] r_i_rdata;
    logic          r_d_gnt;
    logic          r_d_rvalid;
    logic [DW-1:0] r_d_rdata;
    logic          r_m_en;
    logic          r_m_we;
    logic [AW-1:0] r_m_addr;
    logic [DW-1:0] r_m_wdata;
    logic          r_busy;

    logic          w_any_req;
    logic          w_contest;
    logic          w_pick_d;
    logic          w_flush_hit;

    assign w_any_req   = i_req | d_req;
    assign w_contest   = i_req & d_req;
    assign w_flush_hit = ~r_owner_d & i_flush;

`ifdef ARB_RR_EN
    logic r_last_d;

    // Contested grants go to whichever port did not win last time
    assign w_pick_d = d_req & ~(w_contest & r_last_d);

    // Remember the owner of every grant for the next contest
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_last_d <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    localparam int         SW        = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] r_starve;

    // Data wins contests until the fetch port has lost STARVE_MAX in a row
    assign w_pick_d = d_req & ~(w_contest & (r_starve == STARVE_LIM));

    // Count contested data wins; any fetch grant resets the guard
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_starve <= '0;
        end else if (r_state == S_IDLE && w_any_req) begin
            if (!w_pick_d) begin
                r_starve <= '0;
            end else if (w_contest && r_starve != STARVE_LIM) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end
`endif

    // Transaction FSM: latch winner, issue, wait out latency, respond
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner_d    <= 1'b0;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_i_gnt      <= 1'b0;
            r_i_rvalid   <= 1'b0;
            r_i_rdata    <= '0;
            r_d_gnt      <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_d_rdata    <= '0;
            r_m_en       <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_busy       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner_d <= w_pick_d;
                        r_we      <= w_pick_d & d_we;
                        r_m_we    <= w_pick_d & d_we;
                        r_m_addr  <= w_pick_d ? d_addr : i_addr;
                        r_m_wdata <= w_pick_d ? d_wdata : '0;
                        r_m_en    <= 1'b1;
                        r_i_gnt   <= ~w_pick_d;
                        r_d_gnt   <= w_pick_d;
                        r_busy    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_m_en  <= 1'b0;
                    r_m_we  <= 1'b0;
                    r_i_gnt <= 1'b0;
                    r_d_gnt <= 1'b0;
                    r_cnt   <= LAT;
                    if (w_flush_hit) begin
                        r_flush_pend <= 1'b1;
                    end
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (w_flush_hit) begin
                        r_flush_pend <= 1'b1;
                    end
                    // A flush on the final wait cycle still kills the response
                    if (r_cnt == 3'd1) begin
                        if (r_owner_d) begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= r_we ? '0 : m_rdata;
                        end else begin
                            r_i_rvalid <= ~(r_flush_pend | i_flush);
                            r_i_rdata  <= m_rdata;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_i_rvalid   <= 1'b0;
                    r_d_rvalid   <= 1'b0;
                    r_busy       <= 1'b0;
                    r_flush_pend <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign i_gnt    = r_i_gnt;
    assign i_rvalid = r_i_rvalid;
    assign i_rdata  = r_i_rdata;
    assign d_gnt    = r_d_gnt;
    assign d_rvalid = r_d_rvalid;
    assign d_rdata  = r_d_rdata;
    assign m_en     = r_m_en;
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign busy     = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// Honours ARB_RR_EN for the expected contested grant order.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk1 = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_flush;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          busy;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(2), .STARVE_MAX(4)
    ) dut (
        .clk1(clk1), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk1 = ~clk1;

    // Memory model: 2-cycle read latency, junk outside the valid cycle
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] pipe0;
    logic [DW-1:0] pipe1;
    logic          load_en;

    always @(posedge clk1) begin
        if (load_en) begin
            mem[3]  <= 32'h0BADF00D;
            mem[5]  <= 32'hDEADBEEF;
            mem[7]  <= 32'hCAFEF00D;
            mem[10] <= 32'h00000000;
        end else if (m_en && m_we) begin
            mem[m_addr] <= m_wdata;
        end
        pipe0 <= m_en ? mem[m_addr] : 32'h5A5A5A5A;
        pipe1 <= pipe0;
    end

    assign m_rdata = pipe1;

    // Event monitor
    bit gq[$];
    int i_rv  = 0;
    int d_rv  = 0;
    int men   = 0;
    int excl  = 0;

    always @(negedge clk1) begin
        if (i_gnt) gq.push_back(1'b0);
        if (d_gnt) gq.push_back(1'b1);
        if (i_rvalid) i_rv++;
        if (d_rvalid) d_rv++;
        if (m_en) men++;
        if ((i_gnt && d_gnt) || (i_rvalid && d_rvalid)) excl++;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    int       base;
    int       r0;
    int       r1;
    int       m0;
    logic [9:0] exp_ord;
    logic [63:0] got_ord;

    initial begin
        reset   = 1'b1;
        load_en = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        i_flush = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        step_n(2);
        load_en = 1'b0;
        step();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_gnt", {i_gnt, d_gnt}, 0);
        check("rst_rvalid", {i_rvalid, d_rvalid}, 0);
        check("rst_men", {m_en, m_we}, 0);
        check("rst_maddr", m_addr, 0);

        // Instruction read of mem[5]
        reset  = 1'b0;
        i_req  = 1'b1;
        i_addr = 10'd5;
        step();
        i_req = 1'b0;
        check("ird_ignt", i_gnt, 1);
        check("ird_dgnt", d_gnt, 0);
        check("ird_men", m_en, 1);
        check("ird_maddr", m_addr, 5);
        check("ird_busy1", busy, 1);
        step();
        check("ird_men2", m_en, 0);
        check("ird_busy2", busy, 1);
        step();
        check("ird_rv3", i_rvalid, 0);
        step();
        check("ird_rv4", i_rvalid, 1);
        check("ird_data", i_rdata, 32'hDEADBEEF);
        check("ird_busy4", busy, 1);
        step();
        check("ird_busy5", busy, 0);
        check("ird_rv5", i_rvalid, 0);

        // Data write to 10
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'd10;
        d_wdata = 32'h12345678;
        step();
        d_req = 1'b0;
        check("dwr_gnt", d_gnt, 1);
        check("dwr_mwe", m_we, 1);
        check("dwr_maddr", m_addr, 10);
        check("dwr_mwdata", m_wdata, 32'h12345678);
        step_n(3);
        check("dwr_rv", d_rvalid, 1);
        check("dwr_rdata", d_rdata, 0);
        step();

        // Read back address 10
        d_req = 1'b1;
        d_we  = 1'b0;
        step();
        d_req = 1'b0;
        check("drd_gnt", d_gnt, 1);
        check("drd_mwe", m_we, 0);
        step_n(3);
        check("drd_rv", d_rvalid, 1);
        check("drd_data", d_rdata, 32'h12345678);
        step();

        // Second write returns d_rdata to zero
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'd11;
        d_wdata = 32'hA5A5A5A5;
        step();
        d_req = 1'b0;
        d_we  = 1'b0;
        step_n(3);
        check("dwr2_rv", d_rvalid, 1);
        check("dwr2_rdata", d_rdata, 0);
        step();

        // Both ports held: contested grant order
        base   = gq.size();
        r0     = i_rv;
        r1     = d_rv;
        i_req  = 1'b1;
        i_addr = 10'd5;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 10'd10;
        for (int c = 0; c < 200 && gq.size() < base + 10; c++) step();
        i_req = 1'b0;
        d_req = 1'b0;
        for (int c = 0; c < 20 && busy; c++) step();
        check("ord_idle", busy, 0);
`ifdef ARB_RR_EN
        exp_ord = 10'b1010101010;
`else
        exp_ord = 10'b0111101111;
`endif
        for (int k = 0; k < 10; k++) begin
            got_ord = (gq.size() > base + k) ? 64'(gq[base + k]) : 64'd2;
            check($sformatf("order%0d", k), got_ord, 64'(exp_ord[k]));
        end
`ifdef ARB_RR_EN
        check("ord_irv", i_rv - r0, 5);
        check("ord_drv", d_rv - r1, 5);
`else
        check("ord_irv", i_rv - r0, 2);
        check("ord_drv", d_rv - r1, 8);
`endif
        step();

        // Flush an instruction fetch of address 7
        m0     = men;
        r0     = i_rv;
        i_req  = 1'b1;
        i_addr = 10'd7;
        step();
        i_req = 1'b0;
        step();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        step_n(2);
        check("fl_norv", i_rv - r0, 0);
        check("fl_men", men - m0, 1);
        check("fl_rdata", i_rdata, 32'hCAFEF00D);
        check("fl_busy", busy, 0);

        // Next fetch is served normally
        i_req  = 1'b1;
        i_addr = 10'd5;
        step();
        i_req = 1'b0;
        check("fl2_gnt", i_gnt, 1);
        step_n(3);
        check("fl2_rv", i_rvalid, 1);
        check("fl2_data", i_rdata, 32'hDEADBEEF);
        step();

        // Flush during a data read is ignored
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 10'd10;
        step();
        d_req   = 1'b0;
        i_flush = 1'b1;
        step_n(2);
        i_flush = 1'b0;
        step();
        check("dfl_rv", d_rvalid, 1);
        check("dfl_data", d_rdata, 32'h12345678);
        check("dfl_irv", i_rvalid, 0);
        step();

        // Reset in WAIT of a data read
        d_req  = 1'b1;
        d_addr = 10'd10;
        step();
        d_req = 1'b0;
        check("rw_gnt", d_gnt, 1);
        step();
        reset = 1'b1;
        step();
        check("rw_busy", busy, 0);
        check("rw_gnt0", {i_gnt, d_gnt}, 0);
        check("rw_rv0", {i_rvalid, d_rvalid}, 0);
        check("rw_m0", {m_en, m_we}, 0);
        check("rw_maddr", m_addr, 0);
        check("rw_mwdata", m_wdata, 0);
        check("rw_irdata", i_rdata, 0);
        check("rw_drdata", d_rdata, 0);
        reset = 1'b0;
        r1    = d_rv;
        step_n(6);
        check("rw_nodrv", d_rv - r1, 0);
        i_req  = 1'b1;
        i_addr = 10'd3;
        step();
        i_req = 1'b0;
        check("rw_igنt", i_gnt, 1);
        step_n(3);
        check("rw_irv", i_rvalid, 1);
        check("rw_idata", i_rdata, 32'h0BADF00D);
        step();

        check("exclusive", excl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
